// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit path.
// Holds request codes, PIDs, framing constants and the encoder state type.
package usb_pkg;

    localparam logic [2:0] TX_NONE  = 3'd0;
    localparam logic [2:0] TX_DATA0 = 3'd1;
    localparam logic [2:0] TX_ACK   = 3'd2;
    localparam logic [2:0] TX_NAK   = 3'd3;
    localparam logic [2:0] TX_STALL = 3'd4;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
    } tx_state_t;

    // PID byte carries the check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input logic [2:0] code);
        logic [3:0] pid;
        case (code)
            TX_DATA0: pid = PID_DATA0;
            TX_ACK:   pid = PID_ACK;
            TX_NAK:   pid = PID_NAK;
            default:  pid = PID_STALL;
        endcase
        return {~pid, pid};
    endfunction

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15 - i];
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16_gen.sv
// Serial USB CRC16, fed LSB first; register kept in reflected bit order so
// bit 0 is the first remainder bit to go on the wire.
module usb_crc16_gen
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic fb;
    assign fb = bit_in ^ crc[0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        crc <= CRC16_INIT;
        else if (clear)    crc <= CRC16_INIT;
        else if (shift_en) crc <= (crc >> 1) ^ (fb ? POLY_REFL : 16'h0000);
    end

endmodule

// File: rtl/usb_tx_packet_encoder.sv
// USB full-speed packet transmitter: frames SYNC/PID/payload/CRC16/EOP,
// applies bit stuffing and NRZI, and pops payload bytes from the TX FIFO.
module usb_tx_packet_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dp_out,
    output logic       dm_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_t   state, state_nx;
    logic [CW-1:0] bit_cnt, bit_cnt_nx;
    logic [7:0]  sr, sr_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [6:0]  byte_cnt, byte_cnt_nx;
    logic [6:0]  pay_len;
    logic [2:0]  code;
    logic [2:0]  ones, ones_nx;
    logic        stuff, stuff_nx;
    logic        load, load_nx;
    logic        lvl, lvl_nx;
    logic [15:0] crc;

    logic accept, bad_req, bit_end, cur_bit, counted, line_lvl, stuff_due, crc_shift;
    logic [6:0] occ_clamped;

    assign accept      = (state == IDLE) && (tx_packet inside {TX_DATA0, TX_ACK, TX_NAK, TX_STALL});
    assign bad_req     = (state == IDLE) && (tx_packet > TX_STALL);
    assign bit_end     = (state != IDLE) && (bit_cnt == CW'(CLKS_PER_BIT - 1));
    assign occ_clamped = (buffer_occupancy > 7'(MAX_PAYLOAD)) ? 7'(MAX_PAYLOAD) : buffer_occupancy;
    // A freshly popped byte is not registered yet during its first cycle.
    assign cur_bit     = stuff ? 1'b0 : (load ? tx_packet_data[0] : sr[0]);
    assign counted     = state inside {PID, DATA, CRC_LO, CRC_HI};
    assign line_lvl    = cur_bit ? lvl : ~lvl;
    assign stuff_due   = counted && !stuff && cur_bit && (ones == 3'd5);
    assign crc_shift   = (state == DATA) && !stuff && (bit_cnt == '0);

    usb_crc16_gen u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (accept),
        .shift_en (crc_shift),
        .bit_in   (cur_bit),
        .crc      (crc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sr       <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            pay_len  <= '0;
            code     <= TX_NONE;
            ones     <= '0;
            stuff    <= 1'b0;
            load     <= 1'b0;
            lvl      <= 1'b1;
            tx_error <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            sr       <= sr_nx;
            bit_idx  <= bit_idx_nx;
            byte_cnt <= byte_cnt_nx;
            ones     <= ones_nx;
            stuff    <= stuff_nx;
            load     <= load_nx;
            lvl      <= lvl_nx;
            tx_error <= bad_req;
            if (accept) begin
                code    <= tx_packet;
                pay_len <= occ_clamped;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        sr_nx       = load ? tx_packet_data : sr;
        bit_idx_nx  = bit_idx;
        byte_cnt_nx = byte_cnt;
        ones_nx     = ones;
        stuff_nx    = stuff;
        load_nx     = 1'b0;
        lvl_nx      = lvl;
        if (accept) begin
            state_nx    = SYNC;
            bit_cnt_nx  = '0;
            sr_nx       = SYNC_BYTE;
            bit_idx_nx  = '0;
            byte_cnt_nx = '0;
            ones_nx     = '0;
            stuff_nx    = 1'b0;
            lvl_nx      = 1'b1;
        end else if (state != IDLE) begin
            bit_cnt_nx = bit_end ? '0 : bit_cnt + CW'(1);
        end
        if (bit_end) begin
            if (counted && !stuff) ones_nx = (cur_bit && !stuff_due) ? ones + 3'd1 : 3'd0;
            stuff_nx = stuff_due;
            if (state inside {SYNC, PID, DATA, CRC_LO, CRC_HI}) lvl_nx = line_lvl;
            // A stuffed bit holds the FSM and shift register for one bit time.
            if (!stuff_due) begin
                case (state)
                    EOP_SE0: begin
                        if (bit_idx == 3'd0) bit_idx_nx = 3'd1;
                        else begin
                            state_nx   = EOP_J;
                            bit_idx_nx = 3'd0;
                        end
                    end
                    EOP_J: begin
                        state_nx = IDLE;
                        lvl_nx   = 1'b1;
                    end
                    default: begin
                        if (bit_idx != 3'd7) begin
                            bit_idx_nx = bit_idx + 3'd1;
                            sr_nx      = {1'b0, sr[7:1]};
                        end else begin
                            bit_idx_nx = 3'd0;
                            case (state)
                                SYNC: begin
                                    state_nx = PID;
                                    sr_nx    = pid_byte(code);
                                end
                                PID, DATA: begin
                                    if (code != TX_DATA0) state_nx = EOP_SE0;
                                    else if (byte_cnt != pay_len) begin
                                        state_nx    = DATA;
                                        load_nx     = 1'b1;
                                        byte_cnt_nx = byte_cnt + 7'd1;
                                    end else begin
                                        state_nx = CRC_LO;
                                        sr_nx    = ~crc[7:0];
                                    end
                                end
                                CRC_LO: begin
                                    state_nx = CRC_HI;
                                    sr_nx    = ~crc[15:8];
                                end
                                default: state_nx = EOP_SE0;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign get_tx_packet_data = load;
    assign tx_transfer_active = (state != IDLE);

    always_comb begin
        dp_out = 1'b1;
        dm_out = 1'b0;
        case (state)
            IDLE, EOP_J: begin
                dp_out = 1'b1;
                dm_out = 1'b0;
            end
            EOP_SE0: begin
                dp_out = 1'b0;
                dm_out = 1'b0;
            end
            default: begin
                dp_out = line_lvl;
                dm_out = ~line_lvl;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_packet_encoder.sv
// Bench for usb_tx_packet_encoder: a bit-level reference model fills a
// scoreboard of expected line symbols and pop times for each request.
module tb_usb_tx_packet_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dp_out;
    logic       dm_out;

    always #5 clk = ~clk;

    usb_tx_packet_encoder #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dp_out             (dp_out),
        .dm_out             (dm_out)
    );

    // FIFO model: read data is valid combinationally, pointer advances on pop.
    logic [7:0] fifo_mem [256];
    logic [7:0] rd_ptr = 8'd0;
    assign tx_packet_data = fifo_mem[rd_ptr];
    always @(posedge clk) if (get_tx_packet_data) rd_ptr <= rd_ptr + 8'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [1:0] exp_sym [$];
    int         exp_pop [$];
    int         sym_total = 0;
    int         p_cyc = 0;
    int         pops_seen = 0;
    int         pops_base = 0;
    logic [1:0] cur_sym = 2'b11;
    logic [7:0] pay [64];

    always @(negedge clk) begin : mon
        int rel;
        rel = cyc - p_cyc;
        if (rel >= 0 && rel < sym_total * CPB) begin
            if (rel % CPB == 0) begin
                cur_sym = (exp_sym.size() > 0) ? exp_sym.pop_front() : 2'b11;
                chk("active", int'(tx_transfer_active), 1);
            end
            if (rel % CPB == 0 || rel % CPB == CPB - 1)
                chk("line", int'({dp_out, dm_out}), int'(cur_sym));
        end
        if (get_tx_packet_data) begin
            pops_seen = pops_seen + 1;
            chk("pop_time", rel, (exp_pop.size() > 0) ? exp_pop.pop_front() : -1);
        end
    end

    task automatic build_expect(input logic [2:0] code, input int n);
        logic [7:0]  pidb;
        logic [15:0] c;
        logic        b, fb, lvl;
        bit          pb [$];
        bit          st [$];
        int          starts [$];
        int          ones, si;
        case (code)
            3'd1:    pidb = 8'hC3;
            3'd2:    pidb = 8'hD2;
            3'd3:    pidb = 8'h5A;
            default: pidb = 8'h1E;
        endcase
        for (int i = 0; i < 8; i++) pb.push_back(pidb[i]);
        c = 16'hFFFF;
        if (code == 3'd1) begin
            for (int j = 0; j < n; j++) begin
                starts.push_back(pb.size());
                for (int i = 0; i < 8; i++) begin
                    b  = pay[j][i];
                    pb.push_back(b);
                    fb = b ^ c[15];
                    c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                end
            end
            for (int i = 15; i >= 0; i--) pb.push_back(~c[i]);
        end
        for (int i = 0; i < 7; i++) st.push_back(1'b0);
        st.push_back(1'b1);
        ones = 0;
        si   = 0;
        exp_pop.delete();
        for (int k = 0; k < pb.size(); k++) begin
            if (si < starts.size() && starts[si] == k) begin
                exp_pop.push_back(st.size() * CPB);
                si++;
            end
            st.push_back(pb[k]);
            ones = pb[k] ? ones + 1 : 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        exp_sym.delete();
        foreach (st[k]) begin
            if (!st[k]) lvl = ~lvl;
            exp_sym.push_back(lvl ? 2'b10 : 2'b01);
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
        sym_total = exp_sym.size();
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) fifo_mem[rd_ptr + 8'(i)] = pay[i];
    endtask

    // Called at a falling edge; the DUT accepts on the following rising edge.
    task automatic start_pkt(input logic [2:0] code, input logic [6:0] occ, input int n);
        p_cyc = cyc + 1;
        build_expect(code, n);
        pops_base        = pops_seen;
        tx_packet        = code;
        buffer_occupancy = occ;
        @(negedge clk);
        tx_packet = 3'd0;
    endtask

    task automatic finish_pkt(input string tag, input int n);
        int lim;
        lim = 0;
        while (tx_transfer_active && lim < 20000) begin
            @(negedge clk);
            lim++;
        end
        chk({tag, "_len"}, cyc - p_cyc, sym_total * CPB);
        chk({tag, "_pops"}, pops_seen - pops_base, n);
        chk({tag, "_idle"}, int'({dp_out, dm_out}), 2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst            = 1'b0;
        tx_packet        = 3'd0;
        buffer_occupancy = 7'd0;
        #2;
        chk("rst_line", int'({dp_out, dm_out}), 2);
        chk("rst_active", int'(tx_transfer_active), 0);
        chk("rst_get", int'(get_tx_packet_data), 0);
        chk("rst_err", int'(tx_error), 0);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);

        // ACK: 19 bit times, no pops
        start_pkt(3'd2, 7'd5, 0);
        finish_pkt("ack", 0);

        // DATA0 with empty payload
        start_pkt(3'd1, 7'd0, 0);
        finish_pkt("d0_empty", 0);

        // DATA0 FF FF with a request arriving mid-packet
        pay[0] = 8'hFF;
        pay[1] = 8'hFF;
        load_fifo(2);
        start_pkt(3'd1, 7'd2, 2);
        repeat (20 * CPB) @(negedge clk);
        tx_packet = 3'd2;
        @(negedge clk);
        tx_packet = 3'd0;
        finish_pkt("d0_ff", 2);

        // invalid request code
        pops_base = pops_seen;
        tx_packet = 3'd6;
        @(negedge clk);
        chk("err_pulse", int'(tx_error), 1);
        chk("err_line", int'({dp_out, dm_out}), 2);
        tx_packet = 3'd0;
        @(negedge clk);
        chk("err_clear", int'(tx_error), 0);
        chk("err_active", int'(tx_transfer_active), 0);
        chk("err_pops", pops_seen - pops_base, 0);

        // reset in the middle of a long payload
        for (int i = 0; i < 64; i++) pay[i] = 8'(i * 29 + 3);
        load_fifo(64);
        start_pkt(3'd1, 7'd64, 64);
        repeat (30 * CPB) @(negedge clk);
        #2;
        n_rst     = 1'b0;
        sym_total = 0;
        exp_pop.delete();
        #1;
        chk("abort_line", int'({dp_out, dm_out}), 2);
        chk("abort_active", int'(tx_transfer_active), 0);
        chk("abort_get", int'(get_tx_packet_data), 0);
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        start_pkt(3'd2, 7'd0, 0);
        finish_pkt("ack_after_rst", 0);

        // full 64-byte DATA0, then NAK issued the cycle active falls
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(0, 255));
        load_fifo(64);
        start_pkt(3'd1, 7'd64, 64);
        finish_pkt("d0_64", 64);
        start_pkt(3'd3, 7'd0, 0);
        finish_pkt("nak_b2b", 0);

        // occupancy above the limit is clamped
        for (int i = 0; i < 64; i++) pay[i] = (i % 3 == 0) ? 8'hFF : 8'(i);
        load_fifo(64);
        start_pkt(3'd1, 7'd100, 64);
        finish_pkt("d0_clamp", 64);

        start_pkt(3'd4, 7'd0, 0);
        finish_pkt("stall", 0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
